// File: rtl/mc_controller.sv
// ---------------------------------------------------------------------------
// mc_controller
//   Main control unit of a multi-cycle RV32I core. A Moore-style FSM sequences
//   fetch / decode / execute / memory / writeback. Beside it sit the opcode to
//   immediate-format decoder for the immediate extender and the ALU decoder.
//   The unit drives every datapath mux select and write enable.
//
// Parameters
//   SUPPORT_BNE  1: branch funct3=001 inverts the zero test (bne).
//                0: the branch opcode is treated as beq for funct3 000/001.
//
// Ports
//   clk         in   rising-edge system clock
//   reset       in   asynchronous, active-high; forces FETCH
//   op          in   [6:0] instr[6:0] from the instruction register
//   funct3      in   [2:0] instr[14:12]
//   funct7b5    in   instr[30]
//   zero        in   ALU result == 0
//   immsrc      out  [2:0] extender select: 000 I, 001 S, 010 B, 011 J, 100 U
//   alusrca     out  [1:0] 00 PC, 01 oldPC, 10 rs1 reg, 11 constant 0
//   alusrcb     out  [1:0] 00 rs2 reg, 01 immext, 10 constant 4
//   resultsrc   out  [1:0] 00 ALUOut reg, 01 data reg, 10 ALU result
//   adrsrc      out  memory address select: 0 PC, 1 result
//   alucontrol  out  [2:0] 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
//   irwrite     out  load instruction register (and oldPC)
//   pcwrite     out  load PC
//   regwrite    out  register file write
//   memwrite    out  data memory write
//   illegal_op  out  one-cycle pulse in DECODE on an unsupported opcode
// ---------------------------------------------------------------------------
module mc_controller #(
  parameter bit SUPPORT_BNE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [2:0] immsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic       adrsrc,
  output logic [2:0] alucontrol,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       illegal_op
);

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11
  } state_t;

  state_t state_q, state_d;

  // Extender format select, decoded from the opcode alone in every state.
  function automatic logic [2:0] imm_decode(input logic [6:0] opc);
    logic [2:0] sel;
    sel = 3'b000;
    case (opc)
      OP_LW, OP_IALU: sel = 3'b000;
      OP_SW:          sel = 3'b001;
      OP_BRANCH:      sel = 3'b010;
      OP_JAL:         sel = 3'b011;
      OP_LUI:         sel = 3'b100;
      default:        sel = 3'b000;
    endcase
    return sel;
  endfunction

  // ALU operation from the funct fields. Subtraction needs op[5] as well as
  // funct7b5 because I-type immediates reuse instr[30] as an immediate bit.
  function automatic logic [2:0] alu_decode(input logic [6:0] opc,
                                            input logic [2:0] f3,
                                            input logic       f7b5);
    logic [2:0] ctl;
    ctl = ALU_ADD;
    case (f3)
      3'b000:  ctl = (opc[5] && f7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  ctl = ALU_SLT;
      3'b100:  ctl = ALU_XOR;
      3'b110:  ctl = ALU_OR;
      3'b111:  ctl = ALU_AND;
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

  // Branch condition: beq on 000, bne on 001 when enabled, never taken otherwise.
  function automatic logic branch_taken(input logic [2:0] f3, input logic z);
    logic tk;
    tk = 1'b0;
    case (f3)
      3'b000:  tk = z;
      3'b001:  tk = SUPPORT_BNE ? ~z : z;
      default: tk = 1'b0;
    endcase
    return tk;
  endfunction

  // State register: the only sequential element.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  logic pcupdate;
  logic branch;
  logic irwrite_raw;
  logic regwrite_raw;
  logic memwrite_raw;
  logic illegal_raw;

  always_comb begin
    state_d      = S_FETCH;
    alusrca      = 2'b00;
    alusrcb      = 2'b00;
    resultsrc    = 2'b00;
    adrsrc       = 1'b0;
    alucontrol   = ALU_ADD;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    memwrite_raw = 1'b0;
    illegal_raw  = 1'b0;
    pcupdate     = 1'b0;
    branch       = 1'b0;

    case (state_q)
      S_FETCH: begin
        adrsrc      = 1'b0;
        irwrite_raw = 1'b1;
        alusrca     = 2'b00;
        alusrcb     = 2'b10;
        resultsrc   = 2'b10;
        pcupdate    = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target oldPC + immext into ALUOut.
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_IALU:      state_d = S_EXECUTEI;
          OP_BRANCH:    state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          OP_LUI:       state_d = S_LUI;
          default: begin
            illegal_raw = 1'b1;
            state_d     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        resultsrc = 2'b00;
        adrsrc    = 1'b1;
        state_d   = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc    = 2'b01;
        regwrite_raw = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        resultsrc    = 2'b00;
        adrsrc       = 1'b1;
        memwrite_raw = 1'b1;
        state_d      = S_FETCH;
      end
      S_EXECUTER: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b00;
        alucontrol = alu_decode(op, funct3, funct7b5);
        state_d    = S_ALUWB;
      end
      S_EXECUTEI: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b01;
        alucontrol = alu_decode(op, funct3, funct7b5);
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        resultsrc    = 2'b00;
        regwrite_raw = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b00;
        alucontrol = ALU_SUB;
        resultsrc  = 2'b00;
        branch     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // PC <= ALUOut (target) while ALU forms oldPC + 4 for the link write.
        alusrca   = 2'b01;
        alusrcb   = 2'b10;
        resultsrc = 2'b00;
        pcupdate  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_LUI: begin
        alusrca = 2'b11;
        alusrcb = 2'b01;
        state_d = S_ALUWB;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign immsrc = imm_decode(op);

  // Reset holds the FSM in FETCH asynchronously; gating the enables here keeps
  // the FETCH-cycle irwrite/pcwrite from firing while reset is still high.
  assign irwrite    = irwrite_raw  & ~reset;
  assign pcwrite    = (pcupdate | (branch & branch_taken(funct3, zero))) & ~reset;
  assign regwrite   = regwrite_raw & ~reset;
  assign memwrite   = memwrite_raw & ~reset;
  assign illegal_op = illegal_raw  & ~reset;

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [2:0] immsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] resultsrc;
  logic       adrsrc;
  logic [2:0] alucontrol;
  logic       irwrite;
  logic       pcwrite;
  logic       regwrite;
  logic       memwrite;
  logic       illegal_op;

  mc_controller #(.SUPPORT_BNE(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .immsrc(immsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .resultsrc(resultsrc), .adrsrc(adrsrc), .alucontrol(alucontrol),
    .irwrite(irwrite), .pcwrite(pcwrite), .regwrite(regwrite),
    .memwrite(memwrite), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Packed view: [17:15] immsrc [14:13] a [12:11] b [10:9] result [8] adr
  // [7:5] alu [4] ir [3] pcw [2] regw [1] memw [0] illegal
  logic [17:0] obs;
  assign obs = {immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
                irwrite, pcwrite, regwrite, memwrite, illegal_op};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RR = 7'b0110011,
                         II = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                         LU = 7'b0110111;

  function automatic bit is_legal(input logic [6:0] o);
    return o == LW || o == SW || o == RR || o == II || o == BR || o == JL || o == LU;
  endfunction

  // Total cycles an instruction spends, FETCH included.
  function automatic int latency(input logic [6:0] o);
    if (o == LW) return 5;
    if (o == BR) return 3;
    if (is_legal(o)) return 4;
    return 2;
  endfunction

  function automatic logic [2:0] ref_imm(input logic [6:0] o);
    if (o == SW) return 3'd1;
    if (o == BR) return 3'd2;
    if (o == JL) return 3'd3;
    if (o == LU) return 3'd4;
    return 3'd0;
  endfunction

  function automatic logic [2:0] ref_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (f3 == 3'd0) return (o == RR && f7) ? 3'd1 : 3'd0;
    if (f3 == 3'd2) return 3'd5;
    if (f3 == 3'd4) return 3'd4;
    if (f3 == 3'd6) return 3'd3;
    if (f3 == 3'd7) return 3'd2;
    return 3'd0;
  endfunction

  // Expected outputs in cycle k of an instruction (k=0 is the fetch cycle).
  function automatic logic [17:0] ref_vec(input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7, input logic z, input int k);
    logic [1:0] a, b, rs;
    logic       adr, ir, pcw, rw, mw, ill, taken;
    logic [2:0] alu;
    a = 0; b = 0; rs = 0; adr = 0; ir = 0; pcw = 0; rw = 0; mw = 0; ill = 0; alu = 0;
    taken = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : 1'b0;
    if (k == 0) begin
      ir = 1; pcw = 1; b = 2'b10; rs = 2'b10;
    end else if (k == 1) begin
      a = 2'b01; b = 2'b01; ill = !is_legal(o);
    end else if (k == latency(o) - 1 && o != BR) begin
      // last cycle: register or memory write
      if (o == LW) begin rs = 2'b01; rw = 1; end
      else if (o == SW) begin adr = 1; mw = 1; end
      else rw = 1;
    end else if (o == LW && k == 3) begin
      adr = 1;
    end else begin
      // k == 2: address / execute / branch / jal / lui
      if (o == LW || o == SW) begin a = 2'b10; b = 2'b01; end
      else if (o == RR) begin a = 2'b10; alu = ref_alu(o, f3, f7); end
      else if (o == II) begin a = 2'b10; b = 2'b01; alu = ref_alu(o, f3, f7); end
      else if (o == BR) begin a = 2'b10; alu = 3'd1; pcw = taken; end
      else if (o == JL) begin a = 2'b01; b = 2'b10; pcw = 1; end
      else if (o == LU) begin a = 2'b11; b = 2'b01; end
    end
    return {ref_imm(o), a, b, rs, adr, alu, ir, pcw, rw, mw, ill};
  endfunction

  // Runs one instruction starting just after the edge that entered FETCH.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    for (int k = 0; k < latency(o); k++) begin
      @(negedge clk);
      chk($sformatf("op%b f3%0d f7%0d z%0d c%0d", o, f3, f7, z, k), obs, ref_vec(o, f3, f7, z, k));
      @(posedge clk); #1;
    end
  endtask

  logic [6:0] kinds [7];
  logic [6:0] ro;

  initial begin
    kinds[0] = LW; kinds[1] = SW; kinds[2] = RR; kinds[3] = II;
    kinds[4] = BR; kinds[5] = JL; kinds[6] = LU;
    reset = 1'b1; op = SW; funct3 = 0; funct7b5 = 0; zero = 0;
    #12;
    chk("reset_state", obs, ref_vec(SW, 0, 0, 0, 0) & ~18'h1F);
    @(posedge clk); #1;
    reset = 1'b0;

    // directed cases
    run_instr(LW, 3'd2, 1'b0, 1'b0);
    run_instr(SW, 3'd2, 1'b1, 1'b1);
    run_instr(RR, 3'd0, 1'b1, 1'b0);   // sub
    run_instr(II, 3'd0, 1'b1, 1'b0);   // addi never subtracts
    run_instr(BR, 3'd0, 1'b0, 1'b1);   // beq taken
    run_instr(BR, 3'd0, 1'b0, 1'b0);   // beq not taken
    run_instr(BR, 3'd1, 1'b0, 1'b0);   // bne taken
    run_instr(BR, 3'd4, 1'b0, 1'b1);   // unsupported branch funct3
    run_instr(JL, 3'd0, 1'b0, 1'b0);
    run_instr(LU, 3'd0, 1'b0, 1'b0);
    run_instr(7'b1111111, 3'd0, 1'b0, 1'b0);

    // reset while in MEMWRITE
    op = SW; funct3 = 3'd2; funct7b5 = 0; zero = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("sw_pre_reset c%0d", k), obs, ref_vec(SW, 3'd2, 0, 0, k));
      if (k < 3) begin @(posedge clk); #1; end
    end
    #1 reset = 1'b1;
    #1;
    chk("rst_memwrite", {31'd0, memwrite}, 32'd0);
    chk("rst_outputs", obs, ref_vec(SW, 3'd2, 0, 0, 0) & ~18'h1F);
    @(posedge clk); #1;
    chk("rst_hold", obs, ref_vec(SW, 3'd2, 0, 0, 0) & ~18'h1F);
    reset = 1'b0;
    run_instr(SW, 3'd2, 1'b0, 1'b0);

    // randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 7) begin
        ro = 7'($urandom);
        while (is_legal(ro)) ro = 7'($urandom);
      end else begin
        ro = kinds[$urandom_range(0, 6)];
      end
      run_instr(ro, 3'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
